// File: rtl/controller_device.sv
// rtl/controller_device.sv - device end of the serial controller bus; optional turbo via MAPACHE64_CONTROLLER_TURBO_EN
// Debounces 8 buttons, snapshots them on host latch, shifts them out active-low on host clock.
module controller_device #(
  parameter int   DEBOUNCE_CYCLES = 16,
  parameter logic FILL_BIT        = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_enable,
  input  logic [7:0] buttons_in,
  input  logic       controller_clk,
  input  logic       controller_latch,
`ifdef MAPACHE64_CONTROLLER_TURBO_EN
  input  logic [7:0] turbo_mask,
`endif
  output logic       data_B,
  output logic [7:0] buttons_debounced,
  output logic       busy
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [2:0]    clk_sh;
  logic [2:0]    latch_sh;
  logic          clk_rise;
  logic          latch_sync;
  logic          latch_fall;
  logic [CW-1:0] db_cnt [8];
  logic [1:0]    state;
  logic [7:0]    snapshot;
  logic [2:0]    bit_count;
  logic [7:0]    load_value;

  // Two flops to resynchronise the host lines, the third holds the previous value for edge detect
  always_ff @(posedge clk) begin
    if (!rst) begin
      clk_sh   <= '0;
      latch_sh <= '0;
    end else if (clk_enable) begin
      clk_sh   <= {clk_sh[1:0], controller_clk};
      latch_sh <= {latch_sh[1:0], controller_latch};
    end
  end

  assign clk_rise   = clk_sh[1] & ~clk_sh[2];
  assign latch_sync = latch_sh[1];
  assign latch_fall = ~latch_sh[1] & latch_sh[2];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) db_cnt[i] <= '0;
      buttons_debounced <= '0;
    end else if (clk_enable) begin
      for (int i = 0; i < 8; i++) begin
        if (buttons_in[i] == buttons_debounced[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CNT_LAST) begin
          buttons_debounced[i] <= buttons_in[i];
          db_cnt[i]            <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CW'(1);
        end
      end
    end
  end

`ifdef MAPACHE64_CONTROLLER_TURBO_EN
  logic [2:0] latch_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      latch_cnt <= '0;
    end else if (clk_enable && latch_fall) begin
      latch_cnt <= latch_cnt + 3'd1;
    end
  end

  // Turbo buttons read pressed for polls 0-3 of every 8, released for 4-7
  assign load_value = ~(buttons_debounced & ~(turbo_mask & {8{latch_cnt[2]}}));
`else
  assign load_value = ~buttons_debounced;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      snapshot  <= 8'hFF;
      bit_count <= '0;
    end else if (clk_enable) begin
      case (state)
        IDLE: begin
          if (latch_sync) state <= LOAD;
        end
        LOAD: begin
          snapshot <= load_value;
          if (latch_fall) begin
            state     <= SHIFT;
            bit_count <= '0;
          end
        end
        SHIFT: begin
          if (latch_sync) begin
            state     <= LOAD;
            bit_count <= '0;
          end else if (clk_rise) begin
            // The fill enters at line level so the host reads FILL_BIT once the 8 buttons are out
            snapshot  <= {FILL_BIT, snapshot[7:1]};
            bit_count <= bit_count + 3'd1;
            if (bit_count == 3'd7) state <= DONE;
          end
        end
        DONE: begin
          if (latch_sync) begin
            state     <= LOAD;
            bit_count <= '0;
          end else if (clk_rise) begin
            snapshot <= {FILL_BIT, snapshot[7:1]};
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign data_B = snapshot[0];
  assign busy   = (state == SHIFT);

endmodule

// File: tb/tb_controller_device.sv
// tb/tb_controller_device.sv - scoreboard bench for controller_device; turbo polls run when MAPACHE64_CONTROLLER_TURBO_EN is defined
module tb_controller_device;

  localparam int DB = 16;
  localparam int K_DATA = 0;
  localparam int K_BUSY = 1;
  localparam int K_DEB  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clk_enable = 1'b0;
  logic [7:0] buttons_in = 8'h00;
  logic       controller_clk = 1'b0;
  logic       controller_latch = 1'b0;
`ifdef MAPACHE64_CONTROLLER_TURBO_EN
  logic [7:0] turbo_mask = 8'h00;
`endif
  logic       data_B;
  logic [7:0] buttons_debounced;
  logic       busy;

  controller_device #(.DEBOUNCE_CYCLES(DB), .FILL_BIT(1'b1)) dut (
    .clk              (clk),
    .rst              (rst),
    .clk_enable       (clk_enable),
    .buttons_in       (buttons_in),
    .controller_clk   (controller_clk),
    .controller_latch (controller_latch),
`ifdef MAPACHE64_CONTROLLER_TURBO_EN
    .turbo_mask       (turbo_mask),
`endif
    .data_B           (data_B),
    .buttons_debounced(buttons_debounced),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  int         kind_q[$];
  logic [7:0] val_q[$];
  string      name_q[$];
  logic       chk_req = 1'b0;
  int         n_cmp = 0;
  int         n_err = 0;

  // Monitor: whenever a check is requested, pop the oldest expectation and compare
  always @(negedge clk) begin
    if (chk_req) begin
      int         k;
      logic [7:0] v;
      logic [7:0] act;
      string      nm;
      n_cmp++;
      if (kind_q.size() == 0) begin
        n_err++;
        $display("FAIL scoreboard_underflow: output presented with no expectation queued");
      end else begin
        k  = kind_q.pop_front();
        v  = val_q.pop_front();
        nm = name_q.pop_front();
        act = (k == K_DATA) ? {7'd0, data_B} :
              (k == K_BUSY) ? {7'd0, busy} : buttons_debounced;
        if (act !== v) begin
          n_err++;
          $display("FAIL %s: got %h, expected %h", nm, act, v);
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input int kind, input logic [7:0] val, input string name);
    kind_q.push_back(kind);
    val_q.push_back(val);
    name_q.push_back(name);
    chk_req = 1'b1;
    @(negedge clk);
    #1;
    chk_req = 1'b0;
  endtask

  task automatic latch_pulse(input int len);
    controller_latch = 1'b1;
    cycles(len);
    controller_latch = 1'b0;
    cycles(5);
  endtask

  task automatic host_clock();
    controller_clk = 1'b1;
    cycles($urandom_range(4, 7));
    controller_clk = 1'b0;
    cycles($urandom_range(4, 7));
  endtask

  // Reference: line level after i host clocks for a poll of btn (active-low, then released fill)
  function automatic logic exp_serial(input logic [7:0] btn, input int i);
    return (i < 8) ? ~btn[i] : 1'b1;
  endfunction

  task automatic read_and_check(input logic [7:0] btn, input string tag, input int nclk);
    expect_out(K_BUSY, 8'd1, {tag, "_busy"});
    expect_out(K_DATA, {7'd0, exp_serial(btn, 0)}, {tag, "_bit0"});
    for (int i = 1; i <= nclk; i++) begin
      host_clock();
      expect_out(K_DATA, {7'd0, exp_serial(btn, i)}, $sformatf("%s_bit%0d", tag, i));
    end
    if (nclk >= 8) expect_out(K_BUSY, 8'd0, {tag, "_done"});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1);
  end

  initial begin
    logic [7:0] b;

    rst = 1'b0;
    clk_enable = 1'b1;
    cycles(2);
    rst = 1'b1;
    cycles(1);
    expect_out(K_DATA, 8'd1, "reset_data");
    expect_out(K_BUSY, 8'd0, "reset_busy");
    expect_out(K_DEB, 8'h00, "reset_deb");

    buttons_in = 8'h01;
    cycles(DB + 2);
    expect_out(K_DEB, 8'h01, "basic_deb");
    latch_pulse(6);
    read_and_check(8'h01, "basic", 9);

    buttons_in = 8'h00;
    cycles(DB + 4);
    expect_out(K_DEB, 8'h00, "db_clear");
    for (int i = 0; i < 5; i++) begin
      buttons_in[3] = ~buttons_in[3];
      cycles(1);
    end
    buttons_in = 8'h00;
    cycles(2);
    expect_out(K_DEB, 8'h00, "db_toggle");
    buttons_in = 8'h08;
    cycles(DB - 1);
    expect_out(K_DEB, 8'h00, "db_edge15");
    expect_out(K_DEB, 8'h08, "db_edge16");

    clk_enable = 1'b0;
    buttons_in = 8'hF0;
    cycles(DB + 10);
    expect_out(K_DEB, 8'h08, "enable_hold");
    clk_enable = 1'b1;
    cycles(DB + 2);
    expect_out(K_DEB, 8'hF0, "enable_resume");

    buttons_in = 8'hA5;
    cycles(DB + 4);
    latch_pulse(6);
    read_and_check(8'hA5, "pre_relatch", 3);
    controller_latch = 1'b1;
    controller_clk = 1'b1;
    cycles(6);
    expect_out(K_BUSY, 8'd0, "relatch_load");
    controller_latch = 1'b0;
    controller_clk = 1'b0;
    cycles(5);
    read_and_check(8'hA5, "relatch", 8);

    buttons_in = 8'h3C;
    cycles(DB + 4);
    latch_pulse(4);
    read_and_check(8'h3C, "pre_reset", 2);
    rst = 1'b0;
    cycles(1);
    rst = 1'b1;
    expect_out(K_DATA, 8'd1, "midreset_data");
    expect_out(K_BUSY, 8'd0, "midreset_busy");
    expect_out(K_DEB, 8'h00, "midreset_deb");

    for (int p = 0; p < 20; p++) begin
      b = 8'($urandom);
      buttons_in = b;
      cycles(DB + 4);
      expect_out(K_DEB, b, $sformatf("rand%0d_deb", p));
      latch_pulse($urandom_range(1, 8));
      buttons_in = 8'($urandom);
      read_and_check(b, $sformatf("rand%0d", p), 8 + $urandom_range(0, 1));
    end

`ifdef MAPACHE64_CONTROLLER_TURBO_EN
    rst = 1'b0;
    cycles(2);
    rst = 1'b1;
    turbo_mask = 8'h01;
    buttons_in = 8'h01;
    cycles(DB + 4);
    for (int k = 0; k < 8; k++) begin
      latch_pulse(4);
      expect_out(K_DATA, (k < 4) ? 8'd0 : 8'd1, $sformatf("turbo_poll%0d", k));
    end
    expect_out(K_DEB, 8'h01, "turbo_deb");
    turbo_mask = 8'h00;
`endif

    cycles(3);
    if (kind_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard_leftover: %0d expectations never checked, expected 0", kind_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
